// File: rtl/rom_fetch_arbiter.sv
// rom_fetch_arbiter: shares the single 1-cycle-latency character-ROM read
// port between the text pipeline (port A) and the overlay generator
// (port B). Fixed priority to A, with a starvation guard that hands B the
// port after STARVE_LIMIT consecutive A grants made while B was waiting.
module rom_fetch_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       aReq,
   input  logic [2:0] aChar,
   input  logic [3:0] aRow,
   output logic       aAck,
   output logic       aValid,
   output logic [7:0] aData,
   input  logic       bReq,
   input  logic [2:0] bChar,
   input  logic [3:0] bRow,
   output logic       bAck,
   output logic       bValid,
   output logic [7:0] bData,
   output logic       romEnable,
   output logic [2:0] romHigh,
   output logic [3:0] romLow,
   input  logic [7:0] romByte,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2
   } state_t;

   localparam logic [2:0] LIMIT_C = 3'(STARVE_LIMIT);

   state_t     state_r,      state_s;
   logic       grant_b_r,    grant_b_s;
   logic [2:0] starve_cnt_r, starve_cnt_s;
   logic       a_ack_r,      a_ack_s;
   logic       b_ack_r,      b_ack_s;
   logic       a_valid_r,    a_valid_s;
   logic       b_valid_r,    b_valid_s;
   logic [7:0] a_data_r,     a_data_s;
   logic [7:0] b_data_r,     b_data_s;
   logic       rom_en_r,     rom_en_s;
   logic [2:0] rom_high_r,   rom_high_s;
   logic [3:0] rom_low_r,    rom_low_s;
   logic       pick_b_s;
   logic [7:0] fetched_s;

   // Next-state, arbitration, starvation counter and registered-output values.
   always_comb begin
      state_s      = state_r;
      grant_b_s    = grant_b_r;
      starve_cnt_s = starve_cnt_r;
      a_ack_s      = 1'b0;
      b_ack_s      = 1'b0;
      a_valid_s    = 1'b0;
      b_valid_s    = 1'b0;
      a_data_s     = a_data_r;
      b_data_s     = b_data_r;
      rom_en_s     = 1'b0;
      rom_high_s   = rom_high_r;
      rom_low_s    = rom_low_r;
      // B wins when alone, or when A has been favoured STARVE_LIMIT times.
      pick_b_s     = bReq & (~aReq | (starve_cnt_r == LIMIT_C));
      // Codes 4..7 are outside the ROM; romByte would be stale, so force zero.
      fetched_s    = rom_high_r[2] ? 8'h00 : romByte;

      case (state_r)
         IDLE: begin
            if (aReq || bReq) begin
               state_s   = ISSUE;
               grant_b_s = pick_b_s;
               if (pick_b_s) begin
                  b_ack_s    = 1'b1;
                  rom_high_s = bChar;
                  rom_low_s  = bRow;
                  rom_en_s   = ~bChar[2];
               end else begin
                  a_ack_s    = 1'b1;
                  rom_high_s = aChar;
                  rom_low_s  = aRow;
                  rom_en_s   = ~aChar[2];
               end
            end else begin
               state_s = IDLE;
            end
            // Count only A grants that make a waiting B wait longer.
            if (!bReq || pick_b_s) begin
               starve_cnt_s = 3'd0;
            end else if (starve_cnt_r < LIMIT_C) begin
               starve_cnt_s = starve_cnt_r + 3'd1;
            end else begin
               starve_cnt_s = starve_cnt_r;
            end
         end
         ISSUE: begin
            state_s = CAPTURE;
         end
         CAPTURE: begin
            state_s = IDLE;
            if (grant_b_r) begin
               b_valid_s = 1'b1;
               b_data_s  = fetched_s;
            end else begin
               a_valid_s = 1'b1;
               a_data_s  = fetched_s;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Grant, starvation counter, ROM address and requester-facing registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         grant_b_r    <= 1'b0;
         starve_cnt_r <= 3'd0;
         a_ack_r      <= 1'b0;
         b_ack_r      <= 1'b0;
         a_valid_r    <= 1'b0;
         b_valid_r    <= 1'b0;
         a_data_r     <= 8'h00;
         b_data_r     <= 8'h00;
         rom_en_r     <= 1'b0;
         rom_high_r   <= 3'd0;
         rom_low_r    <= 4'd0;
      end else begin
         grant_b_r    <= grant_b_s;
         starve_cnt_r <= starve_cnt_s;
         a_ack_r      <= a_ack_s;
         b_ack_r      <= b_ack_s;
         a_valid_r    <= a_valid_s;
         b_valid_r    <= b_valid_s;
         a_data_r     <= a_data_s;
         b_data_r     <= b_data_s;
         rom_en_r     <= rom_en_s;
         rom_high_r   <= rom_high_s;
         rom_low_r    <= rom_low_s;
      end
   end

   assign aAck      = a_ack_r;
   assign bAck      = b_ack_r;
   assign aValid    = a_valid_r;
   assign bValid    = b_valid_r;
   assign aData     = a_data_r;
   assign bData     = b_data_r;
   assign romEnable = rom_en_r;
   assign romHigh   = rom_high_r;
   assign romLow    = rom_low_r;
   assign busy      = (state_r != IDLE);

endmodule
